shift_add_multiplier_4_bit: RTL
===============================

# shift_add_multiplier_4_bit

Sequential 4x4 unsigned shift-and-add multiplier that produces an 8-bit product in four iterations. Each iteration feeds one partial-product addition through an instance of the 4-bit ripple-carry adder `ripple_carry_adder_4_bit` and consumes its `sum`/`cout`. The block is the iterative reference multiplier against which the approximate multiplier variants are built and compared. A start/done handshake lets a testbench or controller issue back-to-back operations.

## Interface
- No parameters. Widths are fixed at 4-bit operands and an 8-bit product.
- `clk`  input  1  Single clock, rising-edge.
- `rst`  input  1  Reset, asynchronous and active-high.
- `start`  input  1  Request to begin a multiply. Sampled only in IDLE.
- `a`  input  4  Multiplicand, unsigned. Captured when start is accepted.
- `b`  input  4  Multiplier, unsigned. Captured when start is accepted.
- `busy`  output  1  High while state is RUN.
- `done`  output  1  One-cycle pulse: product is valid.
- `product`  output  8  Result. Holds its value until the next completion.

## Operation
- Internal registers:
  - `mcand[3:0]`
  - `acc[3:0]` (upper half of the product)
  - `mplr[3:0]` (lower half, shifts right)
  - `cnt[1:0]`
  - `state`
- Adder hookup: one `ripple_carry_adder_4_bit` instance with `cin` tied to 0.
  - Operand A is `acc`.
  - Operand B is `mcand` if `mplr[0]` is 1, otherwise 4'b0.
- States and transitions:
  - IDLE: if `start`=1, capture `mcand<=a`, `mplr<=b`, `acc<=0`, `cnt<=0`, then go to RUN. Otherwise stay in IDLE.
  - RUN, each cycle: `{acc, mplr} <= {cout, sum, mplr[3:1]}` and `cnt<=cnt+1`. When `cnt`==3, also set `product <= {cout, sum, mplr[3:1]}` and go to DONE.
  - DONE: `done`=1 for this one cycle, then go to IDLE unconditionally.
- Arithmetic: the result is the exact unsigned `a*b`, range 0..225. The carry-out of each addition becomes the MSB of the shifted `acc`, so no bit is lost.
- `start` handling:
  - `start` in RUN or DONE is ignored. It is not queued.
  - `a` and `b` may change freely after acceptance.
- Reset values (asynchronous, on `rst`=1):
  - state=IDLE
  - busy=0, done=0, product=8'h00
  - all internal registers 0

## Timing
- Call the edge that accepts `start` E0.
  - `busy`=1 after E0.
  - Iterations happen at E1 through E4.
  - After E4: `done`=1, `busy`=0, `product` valid.
  - After E5: `done`=0, state IDLE.
- Latency is 4 cycles from acceptance to `done`. Throughput is one operation per 6 cycles.
  - `start` held high continuously is re-accepted at the first IDLE edge (E6).
- `busy` and `done` are never high at the same time.
- Reset mid-operation aborts the operation immediately.
  - No `done` pulse occurs.
  - `product` returns to 0.
  - A `start` on the first edge after `rst` deasserts is accepted normally.

## Configuration
- Macro: `APPROX_MULT_LSB_DROP_EN`.
- Defined: the partial product for multiplier bit 0 is dropped. The first RUN iteration always adds 0 regardless of `mplr[0]`.
  - Result is `a*(b & 4'b1110)`.
  - Latency and handshake are unchanged.
- Undefined: exact multiplication as described in Operation.

## Test plan
- Reset, then `a`=13, `b`=11, `start` for 1 cycle -> `busy` for 4 cycles, then `done`=1 for 1 cycle with `product`=8'h8F (143). With the macro: 8'h82 (130).
- `a`=15, `b`=15 -> `product`=8'hE1 (225). With the macro: 8'hD2 (210). Checks the carry-out path on every iteration.
- `a`=0, `b`=9, and separately `a`=7, `b`=0 -> `product`=8'h00 with `done` pulsed both times. The previous nonzero `product` holds until the respective `done`.
- Pulse `start` with new operands (`a`=3, `b`=3) during RUN of 13x11 -> ignored: the result is still 143 and exactly one `done` pulse occurs.
- Assert `rst` at E2 of 13x11 -> `busy`, `done` and `product` go to 0 immediately with no `done` pulse. After release, 5x6 yields `product`=8'h1E (30). With the macro: 8'h1E (30).
- Hold `start`=1 with `a`=2, `b`=5 -> `done` pulses every 6 cycles, each with `product`=8'h0A (10). With the macro: 8'h08 (8).

Source files
------------

// File: rtl/shift_add_multiplier_4_bit.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_4_bit
//   Iterative 4x4 unsigned shift-and-add multiplier, 8-bit product after four
//   RUN cycles. One partial-product addition per cycle goes through a 4-bit
//   ripple-carry adder; its carry-out becomes the MSB of the shifted
//   accumulator, so the result is exact (0..225).
//
//   Ports:
//     clk      in   1  rising-edge clock
//     rst      in   1  asynchronous, active-high reset
//     start    in   1  begin a multiply (sampled only in IDLE)
//     a        in   4  multiplicand, captured on acceptance
//     b        in   4  multiplier, captured on acceptance
//     busy     out  1  high while in RUN
//     done     out  1  one-cycle pulse, product valid
//     product  out  8  result, held until the next completion
//
//   Build option:
//     APPROX_MULT_LSB_DROP_EN  when defined, the partial product for
//                              multiplier bit 0 is dropped (first iteration
//                              adds 0), giving a*(b & 4'b1110).
// ---------------------------------------------------------------------------

// 4-bit ripple-carry adder used for each partial-product addition.
//   a, b  in   4  operands
//   cin   in   1  carry in
//   sum   out  4  sum bits
//   cout  out  1  carry out
module ripple_carry_adder_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

module shift_add_multiplier_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mcand_q, mcand_d;
  logic [3:0] acc_q,   acc_d;
  logic [3:0] mplr_q,  mplr_d;
  logic [1:0] cnt_q,   cnt_d;
  logic [7:0] prod_q,  prod_d;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       cout;

  // Partial product selected by the current multiplier LSB.
`ifdef APPROX_MULT_LSB_DROP_EN
  // First iteration (cnt 0) corresponds to multiplier bit 0: always add 0.
  assign addend = (mplr_q[0] && (cnt_q != 2'd0)) ? mcand_q : 4'b0000;
`else
  assign addend = mplr_q[0] ? mcand_q : 4'b0000;
`endif

  ripple_carry_adder_4_bit u_adder (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mplr_d  = b;
          acc_d   = 4'd0;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift the sum (with carry) into the accumulator; the bit falling
        // out of the accumulator enters the top of the multiplier register.
        {acc_d, mplr_d} = {cout, sum, mplr_q[3:1]};
        cnt_d           = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          prod_d  = {cout, sum, mplr_q[3:1]};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= 4'd0;
      acc_q   <= 4'd0;
      mplr_q  <= 4'd0;
      cnt_q   <= 2'd0;
      prod_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;
endmodule
